// File: rtl/vga_config_sequencer.sv
// vga_config_sequencer: debounces the switch groups and applies the filter, kernel
// and brightness settings to the VGA system at frame boundaries, ramping the intensity.
module vga_config_sequencer #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter logic [7:0] FADE_STEP       = 8'd17,
   parameter int         CNT_W           = 19
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] sw_brightness,
   input  logic [2:0] sw_filter,
   input  logic [2:0] sw_kernel,
   input  logic       vga_vs,
   output logic [7:0] intensity,
   output logic [2:0] filter_select,
   output logic [2:0] kernel_select,
   output logic       cfg_update,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, PENDING, RAMP} state_t;
   state_t           state, state_nx;
   logic [10:0]      sw_s1, sw_s2, cand, stable;
   logic [CNT_W-1:0] cnt;
   logic             vs_s1, vs_s2, vs_prev, frame_tick, cfg_chg, cfg_nx;
   logic [7:0]       target, stepped, int_nx;
   logic [8:0]       diff;
   logic [2:0]       filt_nx, kern_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_s1   <= '0;
         sw_s2   <= '0;
         cand    <= '0;
         stable  <= '0;
         cnt     <= '0;
         vs_s1   <= 1'b1;
         vs_s2   <= 1'b1;
         vs_prev <= 1'b1;
      end else begin
         sw_s1   <= {sw_brightness, sw_filter, sw_kernel};
         sw_s2   <= sw_s1;
         vs_s1   <= vga_vs;
         vs_s2   <= vs_s1;
         vs_prev <= vs_s2;
         if (sw_s2 != cand) begin
            cand <= sw_s2;
            cnt  <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1))
            stable <= cand;
         else
            cnt <= cnt + 1'b1;
      end
   end

   assign frame_tick = vs_prev & ~vs_s2;
   assign target = stable[10:6] == 5'b00001 ? 8'd51  :
                   stable[10:6] == 5'b00010 ? 8'd102 :
                   stable[10:6] == 5'b00100 ? 8'd153 :
                   stable[10:6] == 5'b01000 ? 8'd204 : 8'd255;
   assign cfg_chg = (stable[5:3] != filter_select) || (stable[2:0] != kernel_select);
   assign diff    = target > intensity ? {1'b0, target} - {1'b0, intensity}
                                       : {1'b0, intensity} - {1'b0, target};
   // Moving by FADE_STEP only when the gap exceeds it keeps the step inside 0..255.
   assign stepped = diff <= {1'b0, FADE_STEP} ? target :
                    target > intensity ? intensity + FADE_STEP : intensity - FADE_STEP;
   assign busy    = state != IDLE;

   always_comb begin
      state_nx = state;
      int_nx   = intensity;
      filt_nx  = filter_select;
      kern_nx  = kernel_select;
      cfg_nx   = 1'b0;
      case (state)
         IDLE:          if (cfg_chg || target != intensity) state_nx = PENDING;
         PENDING, RAMP: if (frame_tick) begin
            filt_nx  = stable[5:3];
            kern_nx  = stable[2:0];
            cfg_nx   = cfg_chg;
            int_nx   = stepped;
            state_nx = stepped == target ? IDLE : RAMP;
         end
         default:       state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         intensity     <= 8'd255;
         filter_select <= '0;
         kernel_select <= '0;
         cfg_update    <= 1'b0;
      end else begin
         state         <= state_nx;
         intensity     <= int_nx;
         filter_select <= filt_nx;
         kernel_select <= kern_nx;
         cfg_update    <= cfg_nx;
      end
   end
endmodule

// File: tb/tb_vga_config_sequencer.sv
// tb_vga_config_sequencer: table vectors, hand-written corner sequences and a random
// run checked against a frame-level model of the settings and intensity ramp.
module tb_vga_config_sequencer;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] sw_brightness = '0;
   logic [2:0] sw_filter = '0;
   logic [2:0] sw_kernel = '0;
   logic       vga_vs = 1'b1;
   logic [7:0] intensity;
   logic [2:0] filter_select, kernel_select;
   logic       cfg_update, busy;
   int         total = 0, bad = 0, cfg_cnt = 0;

   vga_config_sequencer #(.DEBOUNCE_CYCLES(4), .FADE_STEP(8'd64), .CNT_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .sw_brightness(sw_brightness), .sw_filter(sw_filter),
      .sw_kernel(sw_kernel), .vga_vs(vga_vs), .intensity(intensity),
      .filter_select(filter_select), .kernel_select(kernel_select),
      .cfg_update(cfg_update), .busy(busy));

   always #5 clk = ~clk;
   always @(negedge clk) if (cfg_update) cfg_cnt <= cfg_cnt + 1;

   typedef struct {
      logic [4:0] b;
      logic [2:0] f, k;
      logic [7:0] ei;
      logic [2:0] ef, ek;
      int         ecfg;
      logic       ebusy;
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic settle();
      repeat (16) @(negedge clk);
   endtask

   task automatic frame(output int d);
      int c0;
      c0 = cfg_cnt;
      @(negedge clk) vga_vs = 1'b0;
      repeat (5) @(negedge clk);
      vga_vs = 1'b1;
      repeat (4) @(negedge clk);
      d = cfg_cnt - c0;
   endtask

   task automatic set_sw(input logic [4:0] b, input logic [2:0] f, input logic [2:0] k);
      sw_brightness = b;
      sw_filter     = f;
      sw_kernel     = k;
   endtask

   task automatic reset_dut(input logic [4:0] b);
      @(negedge clk);
      set_sw(b, 3'd0, 3'd0);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic logic [7:0] tgt_of(input logic [4:0] b);
      for (int i = 0; i < 5; i++)
         if (b == 5'(1 << i)) return 8'(51 * (i + 1));
      return 8'd255;
   endfunction

   function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] t);
      int c = cur, g = t;
      if (g - c <= 64 && c - g <= 64) return t;
      return 8'(g > c ? c + 64 : c - 64);
   endfunction

   initial begin
      int d;
      logic ok;
      logic [7:0] m_int;
      logic [2:0] m_f, m_k;
      logic [4:0] b;
      logic [2:0] f, k;
      vecs[0]  = '{5'b00001, 3'd0, 3'd0, 8'd191, 3'd0, 3'd0, 0, 1'b1};
      vecs[1]  = '{5'b00001, 3'd0, 3'd0, 8'd127, 3'd0, 3'd0, 0, 1'b1};
      vecs[2]  = '{5'b00001, 3'd0, 3'd0, 8'd63,  3'd0, 3'd0, 0, 1'b1};
      vecs[3]  = '{5'b00001, 3'd0, 3'd0, 8'd51,  3'd0, 3'd0, 0, 1'b0};
      vecs[4]  = '{5'b00001, 3'd5, 3'd3, 8'd51,  3'd5, 3'd3, 1, 1'b0};
      vecs[5]  = '{5'b00100, 3'd5, 3'd3, 8'd115, 3'd5, 3'd3, 0, 1'b1};
      vecs[6]  = '{5'b00100, 3'd5, 3'd3, 8'd153, 3'd5, 3'd3, 0, 1'b0};
      vecs[7]  = '{5'b00000, 3'd5, 3'd3, 8'd217, 3'd5, 3'd3, 0, 1'b1};
      vecs[8]  = '{5'b11000, 3'd5, 3'd3, 8'd255, 3'd5, 3'd3, 0, 1'b0};
      vecs[9]  = '{5'b00010, 3'd2, 3'd7, 8'd191, 3'd2, 3'd7, 1, 1'b1};
      vecs[10] = '{5'b10000, 3'd2, 3'd7, 8'd255, 3'd2, 3'd7, 0, 1'b0};
      vecs[11] = '{5'b01000, 3'd2, 3'd7, 8'd204, 3'd2, 3'd7, 0, 1'b0};

      // reset state
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_int", intensity, 255);
      check("rst_filt", filter_select, 0);
      check("rst_kern", kernel_select, 0);
      check("rst_busy", busy, 0);
      check("rst_cfg", cfg_update, 0);
      settle();
      check("idle_busy", busy, 0);

      // bouncing filter switches never reach the stable vector
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) sw_filter = sw_filter == 3'b101 ? 3'b000 : 3'b101;
         @(negedge clk);
         if (busy) ok = 1'b0;
      end
      check("bounce_busy", ok, 1);
      sw_filter = 3'b101;
      settle();
      check("hold_busy", busy, 1);
      frame(d);
      check("bounce_filt", filter_select, 5);
      check("bounce_cfg", d, 1);

      // settings wait for a frame edge however long it takes
      sw_kernel = 3'b011;
      repeat (1000) @(negedge clk);
      check("novs_kern", kernel_select, 0);
      check("novs_busy", busy, 1);
      frame(d);
      check("vs_kern", kernel_select, 3);
      check("vs_cfg", d, 1);
      check("vs_busy", busy, 0);

      reset_dut(5'b00000);
      settle();
      foreach (vecs[i]) begin
         set_sw(vecs[i].b, vecs[i].f, vecs[i].k);
         settle();
         frame(d);
         check($sformatf("vec%0d_int", i), intensity, vecs[i].ei);
         check($sformatf("vec%0d_filt", i), filter_select, vecs[i].ef);
         check($sformatf("vec%0d_kern", i), kernel_select, vecs[i].ek);
         check($sformatf("vec%0d_cfg", i), d, vecs[i].ecfg);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
      end

      m_int = 8'd204;
      m_f = 3'd2;
      m_k = 3'd7;
      for (int i = 0; i < 40; i++) begin
         b = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
         f = $urandom_range(0, 2) == 0 ? 3'($urandom) : m_f;
         k = $urandom_range(0, 2) == 0 ? 3'($urandom) : m_k;
         set_sw(b, f, k);
         settle();
         check($sformatf("rnd%0d_pre_busy", i), busy,
               {31'd0, m_int != tgt_of(b) || m_f != f || m_k != k});
         frame(d);
         check($sformatf("rnd%0d_cfg", i), d, (m_f != f || m_k != k) ? 1 : 0);
         m_int = ramp(m_int, tgt_of(b));
         m_f = f;
         m_k = k;
         check($sformatf("rnd%0d_int", i), intensity, m_int);
         check($sformatf("rnd%0d_filt", i), filter_select, m_f);
         check($sformatf("rnd%0d_kern", i), kernel_select, m_k);
         check($sformatf("rnd%0d_busy", i), busy, {31'd0, m_int != tgt_of(b)});
      end

      // asynchronous reset in the middle of a ramp
      reset_dut(5'b00001);
      settle();
      frame(d);
      check("mid_int", intensity, 191);
      check("mid_busy", busy, 1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_int", intensity, 255);
      check("arst_busy", busy, 0);
      @(negedge clk) reset_n = 1'b1;
      settle();
      frame(d);
      check("rearm_int", intensity, 191);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
